disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexes one shared 2-bit speed-symbol decoder and segment bus across DIGITS common-anode 7-segment digits.
- Holds a double-buffered frame of per-digit codes (A,B pairs as consumed by the speed decoder) and sequences them onto the decoder inputs.
- Drives active-low digit enables, with a guard gap between digits to prevent ghosting.
- Sits between the speed/state logic of the toy dog and the segment decoder / board anodes.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 50000, clocks each digit stays lit per slot (>=1).
- GUARD, 500, clocks all digits are dark before each slot (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures spd_in and blank_in into the shadow buffer.
- spd_in  input  2*DIGITS  per-digit code; bits [2i+1:2i] = {A,B} for digit i.
- blank_in  input  DIGITS  1 = keep digit i dark for the whole frame.
- code_a  output  1  A input to the shared decoder.
- code_b  output  1  B input to the shared decoder.
- dig_en_n  output  DIGITS  active-low digit enables; at most one bit is low at any time.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- pending  output  1  shadow buffer loaded but not yet committed.

Behaviour:
- Clocking and reset: single clock domain; all outputs are registered.
- Reset values: dig_en_n all 1, code_a=0, code_b=0, frame_done=0, pending=0, idx=0, cnt=0, state=GUARD; active and shadow buffers (codes and blank mask) all 0.
- Reset mid-operation overrides everything, including a concurrent load, and restarts the scan at digit 0 in GUARD.
- States:
  - GUARD: dig_en_n all 1. cnt counts 0..GUARD-1. At cnt==GUARD-1: go to ON, cnt<=0.
  - ON: dig_en_n[idx]=0 unless active blank[idx]=1, in which case all bits stay 1. cnt counts 0..DIV-1. At cnt==DIV-1: go to GUARD, cnt<=0, idx<=idx+1; idx wraps DIGITS-1 -> 0.
- Timing:
  - After reset deasserts, digit 0 lights GUARD clocks later and stays lit DIV clocks.
  - Frame period = DIGITS*(GUARD+DIV) clocks.
- Code outputs: code_a/code_b are registered, and always carry the active code of the digit idx points at next, in both GUARD and ON. This gives the decoder the whole guard time to settle before the digit lights.
- Frame end: frame_done=1 for exactly the cycle in which state becomes GUARD with idx=0, after the last digit's ON slot. It does not pulse after reset.
- Load and commit (double buffering):
  - load=1 copies spd_in/blank_in into the shadow buffer and sets pending=1.
  - At the frame boundary (the same cycle frame_done asserts), if pending=1, shadow is copied to active and pending clears.
  - Codes never change within a frame, so there is no tearing.
  - load while pending=1 overwrites the shadow: last write wins and pending stays 1.
  - load in the same cycle as the commit: the older shadow commits, the new data lands in the shadow, and pending stays 1.
- Width rules: cnt width = clog2(max(DIV,GUARD)); idx width = clog2(DIGITS). No illegal idx values are reachable, and the wrap is explicit.
- Illegal parameter values (DIV<1, GUARD<1, DIGITS outside 2..8): the model raises an elaboration-time error.

Test Plan:
- Reset scan (DIGITS=4, DIV=8, GUARD=2, no load): dig_en_n=1111 for 2 clocks, then 1110 for 8, 1111 for 2, 1101 for 8, and so on. frame_done pulses every 40 clocks; code_a=code_b=0 throughout.
- Load and commit: load spd_in=8'b10_01_00_10 mid-frame. pending=1 until the boundary; the codes seen in the current frame stay 0. In the next frame, digit 0 shows A,B=1,0; digit 1 shows 0,0; digit 2 shows 0,1; digit 3 shows 1,0; pending returns to 0.
- Overwrite and boundary collision: load X, then load Y before the boundary -> only Y is ever displayed. Load Z on the frame_done cycle -> Y commits, Z is displayed one frame later.
- Blank mask: blank_in=4'b0100 committed -> dig_en_n never equals 1011. All slot timing is otherwise unchanged and frame_done still pulses every 40 clocks.
- Reset mid-ON of digit 2 with pending=1 -> next cycle dig_en_n=1111, pending=0, active codes 0; the scan restarts at digit 0 after 2 guard clocks.
- Invariant checked every cycle: at most one dig_en_n bit is low, and code_a/code_b are stable whenever a digit is enabled.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: sequences a double-buffered frame of
// 2-bit speed codes onto a shared decoder with dark guard gaps between digits.
module disp_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [2*DIGITS-1:0]   spd_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic                  code_a,
  output logic                  code_b,
  output logic [DIGITS-1:0]     dig_en_n,
  output logic                  frame_done,
  output logic                  pending
);

  // state   | meaning
  // S_GUARD | all digits dark, decoder settling on the code of digit idx
  // S_ON    | digit idx lit (unless blanked) for DIV clocks

  if (DIGITS < 2 || DIGITS > 8 || DIV < 1 || GUARD < 1) begin : g_bad_param
    $error("disp_scan_ctrl: illegal parameters DIGITS=%0d DIV=%0d GUARD=%0d",
           DIGITS, DIV, GUARD);
  end

  localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {S_GUARD, S_ON} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [2*DIGITS-1:0]   act_code, act_code_nx, shd_code;
  logic [DIGITS-1:0]     act_blank, act_blank_nx, shd_blank;
  logic                  wrap, commit, pending_nx;
  logic [DIGITS-1:0]     dig_nx;
  logic [1:0]            code_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      S_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nx = S_ON;
          cnt_nx   = '0;
        end
      end
      S_ON: begin
        if (cnt == DIV_LAST) begin
          state_nx = S_GUARD;
          cnt_nx   = '0;
          if (idx == IDX_LAST) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_GUARD;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase

    // The commit lands on the same edge that starts the new frame, so the
    // frame that follows sees only the new codes.
    commit       = wrap & pending;
    act_code_nx  = commit ? shd_code  : act_code;
    act_blank_nx = commit ? shd_blank : act_blank;
    pending_nx   = load | (pending & ~commit);

    dig_nx = '1;
    if (state_nx == S_ON && !act_blank_nx[idx_nx])
      dig_nx[idx_nx] = 1'b0;
    code_nx = act_code_nx[{idx_nx, 1'b0} +: 2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_GUARD;
      cnt        <= '0;
      idx        <= '0;
      act_code   <= '0;
      act_blank  <= '0;
      shd_code   <= '0;
      shd_blank  <= '0;
      pending    <= 1'b0;
      dig_en_n   <= '1;
      code_a     <= 1'b0;
      code_b     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      act_code   <= act_code_nx;
      act_blank  <= act_blank_nx;
      if (load) begin
        shd_code  <= spd_in;
        shd_blank <= blank_in;
      end
      pending    <= pending_nx;
      dig_en_n   <= dig_nx;
      code_a     <= code_nx[1];
      code_b     <= code_nx[0];
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (DIGITS=4, DIV=8, GUARD=2); expected
// outputs come from a time-since-reset slot model plus a shadow/active model.
module tb_disp_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int SLOT   = DIV + GUARD;
  localparam int FRAME  = DIGITS * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] spd_in = '0;
  logic [3:0] blank_in = '0;
  logic       code_a, code_b, frame_done, pending;
  logic [3:0] dig_en_n;

  disp_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .load(load), .spd_in(spd_in),
    .blank_in(blank_in), .code_a(code_a), .code_b(code_b),
    .dig_en_n(dig_en_n), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [7:0] m_act = '0, m_shd = '0;
  logic [3:0] m_blk = '0, m_bshd = '0;
  logic       m_pend = 1'b0;
  logic       prev_en = 1'b0;
  logic [1:0] prev_code = '0;

  task automatic check();
    int pos, slot, w;
    logic [3:0] e_dig;
    logic e_a, e_b, e_fd;
    pos  = t % FRAME;
    slot = pos / SLOT;
    w    = pos % SLOT;
    e_dig = (w < GUARD || m_blk[slot]) ? 4'hF : ~(4'b0001 << slot);
    e_a  = m_act[2*slot+1];
    e_b  = m_act[2*slot];
    e_fd = (pos == 0 && t > 0);
    checks++;
    assert (dig_en_n === e_dig) else begin
      errors++; $error("FAIL dig_en_n t=%0d got=%b exp=%b", t, dig_en_n, e_dig);
    end
    checks++;
    assert (code_a === e_a) else begin
      errors++; $error("FAIL code_a t=%0d got=%b exp=%b", t, code_a, e_a);
    end
    checks++;
    assert (code_b === e_b) else begin
      errors++; $error("FAIL code_b t=%0d got=%b exp=%b", t, code_b, e_b);
    end
    checks++;
    assert (frame_done === e_fd) else begin
      errors++; $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_fd);
    end
    checks++;
    assert (pending === m_pend) else begin
      errors++; $error("FAIL pending t=%0d got=%b exp=%b", t, pending, m_pend);
    end
    checks++;
    assert ($countones(~dig_en_n) <= 1) else begin
      errors++; $error("FAIL onehot t=%0d got=%b exp=at_most_one_low", t, dig_en_n);
    end
    if (prev_en && dig_en_n != 4'hF) begin
      checks++;
      assert ({code_a, code_b} === prev_code) else begin
        errors++; $error("FAIL code_stable t=%0d got=%b exp=%b", t, {code_a, code_b}, prev_code);
      end
    end
    prev_en   = (dig_en_n != 4'hF);
    prev_code = {code_a, code_b};
  endtask

  task automatic cyc(input logic ld, input logic [7:0] s, input logic [3:0] b);
    load = ld; spd_in = s; blank_in = b;
    @(negedge clk);
    load = 1'b0;
    t++;
    if (t % FRAME == 0 && m_pend) begin
      m_act = m_shd; m_blk = m_bshd; m_pend = 1'b0;
    end
    if (ld) begin
      m_shd = s; m_bshd = b; m_pend = 1'b1;
    end
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'h0);
  endtask

  task automatic to_pos(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) cyc(1'b0, 8'h00, 4'h0);
  endtask

  // Reset with an optional concurrent load, which reset must override.
  task automatic do_reset(input logic ld);
    reset = 1'b1; load = ld; spd_in = 8'hFF; blank_in = 4'hF;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    m_act = '0; m_shd = '0; m_blk = '0; m_bshd = '0; m_pend = 1'b0;
    t = 0; prev_en = 1'b0;
    check();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    do_reset(1'b0);
    idle(80);

    to_pos(14);
    cyc(1'b1, 8'b10_01_00_10, 4'b0000);
    idle(85);

    to_pos(5);
    cyc(1'b1, 8'b11_11_11_11, 4'b0000);
    idle(3);
    cyc(1'b1, 8'b01_10_11_00, 4'b0000);
    to_pos(FRAME - 1);
    cyc(1'b1, 8'b00_11_01_01, 4'b0000);
    idle(80);

    cyc(1'b1, 8'b11_10_01_11, 4'b0100);
    idle(90);

    to_pos(3);
    cyc(1'b1, 8'b10_10_10_10, 4'b0001);
    to_pos(25);
    do_reset(1'b1);
    idle(45);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
